// File: rtl/cluster_periph_arb_pkg.sv
// Shared types and the round-robin pick for the cluster peripheral arbiter.
// Types are sized from the default configuration (8 requesters, 4 outstanding).
package cluster_periph_arb_pkg;

   localparam int unsigned NReq           = 8;
   localparam int unsigned MaxOutstanding = 4;
   localparam int unsigned IdW            = $clog2(NReq);
   localparam int unsigned OccW           = $clog2(MaxOutstanding) + 1;

   typedef logic [IdW-1:0]  idx_t;
   typedef logic [OccW-1:0] occ_t;

   // First asserted requester at or after ptr, modulo NReq; returns ptr when none.
   function automatic idx_t rr_pick(input logic [NReq-1:0] req, input idx_t ptr);
      idx_t        win;
      int unsigned k;
      win = ptr;
      // Walk from the farthest offset down so the nearest match is written last.
      for (int unsigned i = NReq; i > 0; i--) begin
         k = (int'(ptr) + int'(i) - 1) % NReq;
         if (req[k]) win = idx_t'(k);
      end
      return win;
   endfunction

endpackage

// File: rtl/cluster_periph_arb_fifo.sv
// In-order FIFO of requester indices, used to route responses back to their issuer.
module cluster_periph_arb_fifo
   import cluster_periph_arb_pkg::*;
#(
   parameter int unsigned DEPTH = MaxOutstanding
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  idx_t data_i,
   input  logic pop_i,
   output idx_t head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   idx_t            mem_q [DEPTH];
   logic [PtrW-1:0] wptr_q, rptr_q;
   occ_t            cnt_q;
   logic            push_ok, pop_ok;

   always_comb begin
      full_o  = (cnt_q == occ_t'(DEPTH));
      empty_o = (cnt_q == '0);
      push_ok = push_i & ~full_o;
      pop_ok  = pop_i & ~empty_o;
      head_o  = mem_q[rptr_q];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop_ok) rptr_q <= rptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/cluster_periph_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port among N_REQ requesters.
// Optional perf outputs are enabled by defining CLUSTER_PERIPH_ARB_PERF_EN.
module cluster_periph_arbiter
   import cluster_periph_arb_pkg::*;
#(
   parameter int unsigned N_REQ           = 8,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [N_REQ-1:0]              req_i,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   add_i,
   input  logic [N_REQ-1:0]              wen_i,
   input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
   input  logic [N_REQ*BE_WIDTH-1:0]     be_i,
   output logic [N_REQ-1:0]              gnt_o,
   output logic [N_REQ-1:0]              r_valid_o,
   output logic [DATA_WIDTH-1:0]         r_rdata_o,
   output logic                          r_opc_o,
   output logic                          req_o,
   output logic [ADDR_WIDTH-1:0]         add_o,
   output logic                          wen_o,
   output logic [DATA_WIDTH-1:0]         wdata_o,
   output logic [BE_WIDTH-1:0]           be_o,
   output logic [$clog2(N_REQ)-1:0]      id_o,
   input  logic                          gnt_i,
   input  logic                          r_valid_i,
   input  logic [DATA_WIDTH-1:0]         r_rdata_i,
   input  logic                          r_opc_i,
   output logic                          err_o
`ifdef CLUSTER_PERIPH_ARB_PERF_EN
   ,
   output logic [N_REQ-1:0]              perf_contention_o,
   output logic                          perf_full_o
`endif
);

   // Index and occupancy types come from the package, so the sizes must agree.
   if (N_REQ != NReq || MAX_OUTSTANDING != MaxOutstanding) begin : g_cfg_check
      $error("cluster_periph_arbiter: N_REQ/MAX_OUTSTANDING must match cluster_periph_arb_pkg");
   end

   idx_t rr_q, rr_nxt;
   idx_t lock_idx_q;
   logic lock_vld_q;
   logic err_q;

   idx_t win, head;
   logic any_req, xfer, pop;
   logic fifo_full, fifo_empty;

   // Request path: a presented-but-ungranted winner stays locked until granted.
   always_comb begin
      any_req = |req_i;
      req_o   = any_req & ~fifo_full;
      if (lock_vld_q && req_i[lock_idx_q]) win = lock_idx_q;
      else                                 win = rr_pick(req_i, rr_q);
      xfer    = req_o & gnt_i;
      rr_nxt  = (win == idx_t'(N_REQ - 1)) ? '0 : win + 1'b1;

      gnt_o   = '0;
      add_o   = '0;
      wen_o   = 1'b0;
      wdata_o = '0;
      be_o    = '0;
      id_o    = '0;
      if (req_o) begin
         add_o   = add_i[win*ADDR_WIDTH +: ADDR_WIDTH];
         wen_o   = wen_i[win];
         wdata_o = wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
         be_o    = be_i[win*BE_WIDTH +: BE_WIDTH];
         id_o    = win;
      end
      if (xfer) gnt_o[win] = 1'b1;
   end

   // Response path: a response with nothing outstanding is dropped, not routed.
   always_comb begin
      pop       = r_valid_i & ~fifo_empty;
      r_valid_o = '0;
      if (pop) r_valid_o[head] = 1'b1;
      r_rdata_o = pop ? r_rdata_i : '0;
      r_opc_o   = pop & r_opc_i;
      err_o     = err_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_idx_q <= '0;
         lock_vld_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (xfer) begin
            rr_q       <= rr_nxt;
            lock_vld_q <= 1'b0;
         end else if (req_o) begin
            lock_vld_q <= 1'b1;
            lock_idx_q <= win;
         end
         if (r_valid_i && fifo_empty) err_q <= 1'b1;
      end
   end

   cluster_periph_arb_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (xfer),
      .data_i  (win),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef CLUSTER_PERIPH_ARB_PERF_EN
   logic perf_full_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perf_full_q <= 1'b0;
      else         perf_full_q <= fifo_full;
   end

   assign perf_full_o       = perf_full_q;
   assign perf_contention_o = req_i & ~gnt_o;
`endif

endmodule

// File: tb/tb_cluster_periph_arbiter.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_cluster_periph_arbiter;

   localparam int N  = 8;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req_i = '0;
   logic [N-1:0]    wen_i = '0;
   logic [AW-1:0]   add_a   [N];
   logic [DW-1:0]   wdata_a [N];
   logic [BW-1:0]   be_a    [N];
   logic [N*AW-1:0] add_i;
   logic [N*DW-1:0] wdata_i;
   logic [N*BW-1:0] be_i;
   logic            gnt_i = 1'b0;
   logic            r_valid_i = 1'b0;
   logic [DW-1:0]   r_rdata_i = '0;
   logic            r_opc_i = 1'b0;

   logic [N-1:0]    gnt_o, r_valid_o;
   logic [DW-1:0]   r_rdata_o, wdata_o;
   logic            r_opc_o, req_o, wen_o, err_o;
   logic [AW-1:0]   add_o;
   logic [BW-1:0]   be_o;
   logic [2:0]      id_o;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         add_i[i*AW +: AW]   = add_a[i];
         wdata_i[i*DW +: DW] = wdata_a[i];
         be_i[i*BW +: BW]    = be_a[i];
      end
   end

   cluster_periph_arbiter dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .add_i     (add_i),
      .wen_i     (wen_i),
      .wdata_i   (wdata_i),
      .be_i      (be_i),
      .gnt_o     (gnt_o),
      .r_valid_o (r_valid_o),
      .r_rdata_o (r_rdata_o),
      .r_opc_o   (r_opc_o),
      .req_o     (req_o),
      .add_o     (add_o),
      .wen_o     (wen_o),
      .wdata_o   (wdata_o),
      .be_o      (be_o),
      .id_o      (id_o),
      .gnt_i     (gnt_i),
      .r_valid_i (r_valid_i),
      .r_rdata_i (r_rdata_i),
      .r_opc_i   (r_opc_i),
      .err_o     (err_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: next-priority index, pending (ungranted) winner,
   // queue of issuers awaiting a response, sticky error, last cycle's grants.
   int           m_rr = 0;
   int           m_pend = -1;
   int           m_q[$];
   bit           m_err = 1'b0;
   logic [N-1:0] m_gnt_last = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : compare
      int           w;
      bit           full, exp_req, xfer, pop;
      logic [N-1:0] exp_gnt, exp_rv;
      if (!rst_ni) begin
         m_rr = 0;
         m_pend = -1;
         m_q.delete();
         m_err = 1'b0;
         m_gnt_last = '0;
         check("rst_err", err_o, 0);
         check("rst_req_o", req_o, 0);
         check("rst_gnt", gnt_o, 0);
      end else begin
         full = (m_q.size() == MO);
         w = -1;
         if (m_pend >= 0 && req_i[m_pend]) w = m_pend;
         else
            for (int k = 0; k < N; k++)
               if (w < 0 && req_i[(m_rr + k) % N]) w = (m_rr + k) % N;
         exp_req = (w >= 0) && !full;
         xfer    = exp_req && gnt_i;
         exp_gnt = '0;
         if (xfer) exp_gnt[w] = 1'b1;
         pop     = r_valid_i && (m_q.size() > 0);
         exp_rv  = '0;
         if (pop) exp_rv[m_q[0]] = 1'b1;

         check("req_o", req_o, exp_req);
         check("gnt_o", gnt_o, exp_gnt);
         check("add_o", add_o, exp_req ? add_a[w] : '0);
         check("wen_o", wen_o, exp_req ? wen_i[w] : 1'b0);
         check("wdata_o", wdata_o, exp_req ? wdata_a[w] : '0);
         check("be_o", be_o, exp_req ? be_a[w] : '0);
         check("id_o", id_o, exp_req ? w : 0);
         check("r_valid_o", r_valid_o, exp_rv);
         check("r_rdata_o", r_rdata_o, pop ? r_rdata_i : '0);
         check("r_opc_o", r_opc_o, pop ? r_opc_i : 1'b0);
         check("err_o", err_o, m_err);

         if (r_valid_i && m_q.size() == 0) m_err = 1'b1;
         if (pop) void'(m_q.pop_front());
         if (xfer) begin
            m_q.push_back(w);
            m_rr = (w + 1) % N;
            m_pend = -1;
         end else if (exp_req) begin
            m_pend = w;
         end
         m_gnt_last = exp_gnt;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      req_i = '0;
      gnt_i = 1'b0;
      r_valid_i = 1'b0;
      rst_ni = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
   endtask

   task automatic new_payload(input int i);
      add_a[i]   = $urandom;
      wdata_a[i] = $urandom;
      be_a[i]    = BW'($urandom);
      wen_i[i]   = 1'($urandom);
   endtask

   initial begin : stim
      bit hold;
      for (int i = 0; i < N; i++) begin
         add_a[i]   = 32'h1000_0000 + 32'(i * 4);
         wdata_a[i] = 32'hA000_0000 + 32'(i);
         be_a[i]    = 4'hF;
      end
      do_reset();

      // Single requester 2 write, response the next cycle.
      step();
      req_i = 8'b0000_0100;
      add_a[2] = 32'h1020_0004;
      wdata_a[2] = 32'hDEAD_BEEF;
      be_a[2] = 4'hF;
      wen_i[2] = 1'b0;
      gnt_i = 1'b1;
      #2;
      check("t1_gnt", gnt_o, 8'b0000_0100);
      check("t1_id", id_o, 2);
      check("t1_add", add_o, 32'h1020_0004);
      check("t1_wdata", wdata_o, 32'hDEAD_BEEF);
      step();
      req_i = '0;
      gnt_i = 1'b0;
      r_valid_i = 1'b1;
      r_rdata_i = '0;
      r_opc_i = 1'b0;
      #2;
      check("t1_rvalid", r_valid_o, 8'b0000_0100);
      step();
      r_valid_i = 1'b0;
      add_a[2] = 32'h1000_0008;

      // All requesters continuously, single-cycle slave.
      do_reset();
      for (int k = 0; k <= 8; k++) begin
         step();
         req_i = '1;
         gnt_i = 1'b1;
         r_valid_i = (k > 0);
         r_rdata_i = $urandom;
         #2;
         check("t2_id", id_o, k % 8);
         if (k > 0) check("t2_rvalid", r_valid_o, 64'd1 << ((k - 1) % 8));
      end
      step();
      req_i = '0;
      gnt_i = 1'b0;
      #2;
      check("t2_rvalid_last", r_valid_o, 8'b0000_0001);
      step();
      r_valid_i = 1'b0;

      // Lock: 1 presented while gnt_i=0; a later requester 0 must not steal it.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step();
         req_i = (k >= 2) ? 8'b0000_1011 : 8'b0000_1010;
         #2;
         check("t3_id_locked", id_o, 1);
         check("t3_add_stable", add_o, 32'h1000_0004);
         check("t3_no_gnt", gnt_o, 0);
      end
      step();
      gnt_i = 1'b1;
      #2;
      check("t3_gnt1", gnt_o, 8'b0000_0010);
      step();
      req_i = 8'b0000_1001;
      #2;
      check("t3_gnt3", gnt_o, 8'b0000_1000);
      step();
      req_i = 8'b0000_0001;
      #2;
      check("t3_gnt0", gnt_o, 8'b0000_0001);
      for (int k = 0; k < 3; k++) begin
         step();
         req_i = '0;
         gnt_i = 1'b0;
         r_valid_i = 1'b1;
         #2;
         check("t3_rvalid", r_valid_o, (k == 0) ? 64'h2 : (k == 1) ? 64'h8 : 64'h1);
      end
      step();
      r_valid_i = 1'b0;

      // FIFO full, pop that does not unblock, then push+pop at occupancy 2.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step();
         req_i = '1;
         gnt_i = 1'b1;
         #2;
         check("t4_fill_gnt", gnt_o, 64'd1 << k);
      end
      step();
      #2;
      check("t4_full_req", req_o, 0);
      check("t4_full_gnt", gnt_o, 0);
      step();
      r_valid_i = 1'b1;
      #2;
      check("t4_pop_blocked", req_o, 0);
      check("t4_pop_rv", r_valid_o, 8'b0000_0001);
      step();
      r_valid_i = 1'b0;
      #2;
      check("t4_unblock_gnt", gnt_o, 8'b0001_0000);
      for (int k = 1; k <= 2; k++) begin
         step();
         req_i = '0;
         r_valid_i = 1'b1;
         #2;
         check("t4_drain_rv", r_valid_o, 64'd1 << k);
      end
      step();
      req_i = '1;
      #2;
      check("t4_pp_rv", r_valid_o, 8'b0000_1000);
      check("t4_pp_gnt", gnt_o, 8'b0010_0000);
      for (int k = 4; k <= 6; k++) begin
         step();
         req_i = '0;
         gnt_i = 1'b0;
         #2;
         check("t4_tail_rv", r_valid_o, (k == 6) ? 64'd0 : (64'd1 << k));
      end
      step();
      r_valid_i = 1'b0;
      #2;
      check("t4_err", err_o, 1);

      // Response with nothing outstanding after reset.
      do_reset();
      #2;
      check("t5_err_clear", err_o, 0);
      step();
      r_valid_i = 1'b1;
      r_rdata_i = 32'h1234_5678;
      #2;
      check("t5_rv_dropped", r_valid_o, 0);
      check("t5_rdata_zero", r_rdata_o, 0);
      step();
      r_valid_i = 1'b0;
      #2;
      check("t5_err_set", err_o, 1);
      repeat (3) step();
      #2;
      check("t5_err_sticky", err_o, 1);
      do_reset();
      #2;
      check("t5_err_reset", err_o, 0);

      // Randomized traffic with a reset in the middle.
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         step();
         for (int i = 0; i < N; i++) begin
            if (req_i[i] && m_gnt_last[i]) req_i[i] = 1'b0;
            if (!req_i[i] && ($urandom % 3 == 0)) begin
               req_i[i] = 1'b1;
               new_payload(i);
            end
         end
         hold = (c % 64) < 16;
         gnt_i = ($urandom % 4) != 0;
         r_valid_i = !hold && (m_q.size() > 0) && ($urandom % 3 != 0);
         r_rdata_i = $urandom;
         r_opc_i = 1'($urandom);
      end
      step();
      req_i = '0;
      r_valid_i = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cluster_periph_arbiter.md
# cluster_periph_arbiter

Round-robin arbiter that shares one cluster peripheral control port (event unit, DMA control or peripheral interconnect slave) between `N_REQ` core-side requesters. It sits between the per-core peripheral buses produced by the core demultiplexers and the single `XBAR_PERIPH_BUS`-style slave. It tracks outstanding transactions in order and routes every response back to the requester that issued it.

## Interface
Parameters:
- `N_REQ`, 8: number of requesters; must be ≥2.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `BE_WIDTH`, DATA_WIDTH/8: byte-enable width.
- `MAX_OUTSTANDING`, 4: depth of the response-routing FIFO; must be a power of two, ≥2.

Ports (`IDW` = $clog2(N_REQ)):
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, N_REQ: per-requester request.
- `add_i`, in, N_REQ×ADDR_WIDTH: per-requester address.
- `wen_i`, in, N_REQ: per-requester write-enable; 1 = read, 0 = write.
- `wdata_i`, in, N_REQ×DATA_WIDTH: per-requester write data.
- `be_i`, in, N_REQ×BE_WIDTH: per-requester byte enables.
- `gnt_o`, out, N_REQ: per-requester grant; one-hot or zero.
- `r_valid_o`, out, N_REQ: per-requester response valid; one-hot or zero.
- `r_rdata_o`, out, DATA_WIDTH: response data, broadcast to all requesters.
- `r_opc_o`, out, 1: response error flag, broadcast to all requesters.
- `req_o`, out, 1: master request.
- `add_o`, out, ADDR_WIDTH: master address.
- `wen_o`, out, 1: master write-enable.
- `wdata_o`, out, DATA_WIDTH: master write data.
- `be_o`, out, BE_WIDTH: master byte enables.
- `id_o`, out, IDW: index of the winning requester.
- `gnt_i`, in, 1: master grant.
- `r_valid_i`, in, 1: master response valid.
- `r_rdata_i`, in, DATA_WIDTH: master response data.
- `r_opc_i`, in, 1: master response error flag.
- `err_o`, out, 1: sticky protocol error (response received with no transaction outstanding).

## Operation
- **Arbitration:** combinational round-robin over `req_i`, starting at pointer `rr_q`.
  - Winner `w` is the first asserted requester at or after `rr_q`, modulo N_REQ.
  - `req_o` = (any `req_i`) & ~`fifo_full`.
  - `add_o`/`wen_o`/`wdata_o`/`be_o`/`id_o` mux from `w`. When `req_o`=0 they are driven to 0.
- **Handshake:**
  - A transfer occurs when `req_o & gnt_i`; `gnt_o[w]` = `gnt_i & req_o` in the same cycle.
  - On a transfer, `rr_q` ← (w+1) mod N_REQ. Otherwise `rr_q` holds.
  - Requesters must hold request and payload stable until granted. The arbiter does not re-arbitrate a request that has been presented but not yet granted away from it while `gnt_i`=0: `w` is locked in `lock_q` until granted.
- **Response routing:**
  - On each transfer, `w` is pushed into the FIFO.
  - On `r_valid_i`, the head entry `h` is popped and `r_valid_o[h]`=1 in the same cycle; `r_rdata_o`/`r_opc_o` pass through combinationally.
  - Responses are strictly in order.
- **Boundary conditions:**
  - FIFO full: `req_o` is held at 0 and no grants are issued. A pop in the same cycle does not unblock that cycle.
  - Push and pop in the same cycle: both occur and the count is unchanged; this is legal at full only as pop-only.
  - `r_valid_i` with the FIFO empty: response dropped, `r_valid_o`=0, `err_o` set until reset.
  - Pointer wrap: occupancy is tracked with an (log2(MAX_OUTSTANDING)+1)-bit count; read/write pointers wrap naturally.
  - Reset mid-operation: FIFO and lock cleared. Any later response hits the empty-FIFO case.

## Timing
- Request path is fully combinational (0-cycle arbitration).
- Response path is combinational (0-cycle).
- The master's response arrives ≥1 cycle after its grant.
- One transfer per cycle maximum. Sustained throughput is 1/cycle when the slave returns responses at 1/cycle with MAX_OUTSTANDING ≥ slave latency+1.
- Reset values: `rr_q`=0, `lock_q` cleared, FIFO empty, `err_o`=0. All outputs are 0 while `req_i`=0 and `r_valid_i`=0.

## Configuration
- Macro `CLUSTER_PERIPH_ARB_PERF_EN`.
- When defined:
  - Adds output `perf_contention_o` [N_REQ-1:0]. Bit i is 1 in every cycle where `req_i[i]`=1 and `gnt_o[i]`=0, for use as external perf counter inputs.
  - Adds a registered output `perf_full_o`, which is 1 in the cycle after the FIFO was full.
- When undefined: neither port exists and no associated logic is synthesized.

## Structure
- Package `cluster_periph_arb_pkg`:
  - `idx_t` requester index typedef (IDW bits).
  - `occ_t` occupancy typedef.
  - Function `rr_pick(req, ptr)` returning the round-robin winner.
- Sub-module `cluster_periph_arb_fifo`: in-order index FIFO with push/pop/full/empty/head, same clock and reset.

## Test plan
- Requester 2 alone: writes addr 0x1020_0004, data 0xDEAD_BEEF, be 0xF, `gnt_i`=1 → `gnt_o`=0b100, `id_o`=2. Response in the next cycle (`r_opc_i`=0) → `r_valid_o`=0b100.
- All 8 requesters asserted continuously, `gnt_i`=1, single-cycle slave → grants in the order 0,1,…,7,0. Each response is routed to the issuing index.
- `gnt_i`=0 for 5 cycles while requesters 1 and 3 are asserted → `lock_q` holds 1, payload stable. `gnt_i`=1 → `gnt_o`=0b0010, and 3 wins next.
- Slave withholds responses: 4 grants, then `req_o`=0 with the FIFO full. `r_valid_i` for one cycle → one grant in the following cycle.
- Push and pop in the same cycle at occupancy 2 → occupancy stays 2; the response goes to the older index.
- `r_valid_i` after reset with no outstanding transactions → `r_valid_o`=0 and `err_o`=1 until the next reset.
